// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-port controller.
// Holds the FSM states, byte-enable constants, access-size codes and the alignment rule.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

    // Size codes match the byteword control bit from decode
    localparam logic BYTE = 1'b0;
    localparam logic WORD = 1'b1;

    // A word access is legal only at a word-aligned address
    function automatic logic is_misaligned(input logic byteword, input logic [1:0] addr_lo);
        return (byteword == WORD) && (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-cache request/acknowledge port.
// The controller drives it through the master modport; the cache or its model uses slave.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [3:0]        dc_be;
    logic [31:0]       dc_wdata;
    logic              dc_ack;
    logic [31:0]       dc_rdata;

    modport master (
        output dc_req, dc_we, dc_addr, dc_be, dc_wdata,
        input  dc_ack, dc_rdata
    );

    modport slave (
        input  dc_req, dc_we, dc_addr, dc_be, dc_wdata,
        output dc_ack, dc_rdata
    );
endinterface

// File: rtl/mem_access_ctrl_byte_lane.sv
// Combinational little-endian byte-lane steering.
// Computes store enables and replicated store data, and extracts and zero-extends load data.
module mem_byte_lane
    import mem_access_ctrl_pkg::*;
(
    input  logic        byteword,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] dc_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_fmt
);
    logic [7:0] rd_bytes [4];
    logic [3:0] byte_be;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_bytes[gi] = dc_rdata[8*gi +: 8];
        assign byte_be[gi]  = (addr_lo == 2'(gi));
    end

    // A byte store copies the byte into every lane; the enables select the lane that is written
    assign be        = (byteword == WORD) ? BE_WORD  : byte_be;
    assign wdata_out = (byteword == WORD) ? wdata    : {4{wdata[7:0]}};
    assign rdata_fmt = (byteword == WORD) ? dc_rdata : {24'b0, rd_bytes[addr_lo]};

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues one data-cache transaction per instruction,
// stalls the pipeline until it completes, and reports misalignment and port timeouts.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              byteword,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              exc_misaligned,
    output logic              bus_err,
    mem_access_ctrl_if.master dc
);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [3:0]        be_reg, be_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic              rv_reg, rv_next;
    logic              mis_reg, mis_next;
    logic              err_reg, err_next;

    logic              op;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;

    assign op = memread | memwrite;

    // The EX/MEM register is frozen while stalled, so the live address and size
    // still describe the outstanding access when the read data returns.
    mem_byte_lane u_lane (
        .byteword  (byteword),
        .addr_lo   (addr[1:0]),
        .wdata     (wdata),
        .dc_rdata  (dc.dc_rdata),
        .be        (lane_be),
        .wdata_out (lane_wdata),
        .rdata_fmt (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            be_reg    <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            rv_reg    <= 1'b0;
            mis_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            req_reg   <= req_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            be_reg    <= be_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            rv_reg    <= rv_next;
            mis_reg   <= mis_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_next   = req_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        be_next    = be_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        rv_next    = 1'b0;
        mis_next   = 1'b0;
        err_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (op) begin
                    if (memread && memwrite) begin
                        err_next   = 1'b1;
                        state_next = ST_DONE;
                    end else if (is_misaligned(byteword, addr[1:0])) begin
                        mis_next   = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        addr_next  = {addr[ADDR_W-1:2], 2'b00};
                        be_next    = lane_be;
                        wdata_next = lane_wdata;
                        we_next    = memwrite;
                        req_next   = 1'b1;
                        cnt_next   = '0;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cnt_next = cnt_reg + 1'b1;
                if (dc.dc_ack) begin
                    req_next   = 1'b0;
                    state_next = ST_DONE;
                    if (!we_reg) begin
                        rdata_next = lane_rdata;
                        rv_next    = 1'b1;
                    end
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    // Low in DONE so the pipeline advances exactly once per instruction
    assign stall = ((state_reg == ST_IDLE) && op) || (state_reg == ST_REQ);

    assign rdata          = rdata_reg;
    assign rdata_valid    = rv_reg;
    assign exc_misaligned = mis_reg;
    assign bus_err        = err_reg;

    assign dc.dc_req   = req_reg;
    assign dc.dc_we    = we_reg;
    assign dc.dc_addr  = addr_reg;
    assign dc.dc_be    = be_reg;
    assign dc.dc_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT = 4: loads, stores, misalignment,
// conflicting requests, port timeout and reset during an outstanding request.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        memread, memwrite, byteword;
    logic [31:0] addr, wdata;
    logic        stall, rdata_valid, exc_misaligned, bus_err;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    // Per-transaction observations
    int          stall_cnt, req_cnt, rv_cnt, mis_cnt, err_cnt;
    logic [31:0] r_cap, a_cap, wd_cap;
    logic [3:0]  be_cap;
    logic        we_cap;

    mem_access_ctrl_if #(.ADDR_W(32)) dc_bus ();

    mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .memread        (memread),
        .memwrite       (memwrite),
        .byteword       (byteword),
        .addr           (addr),
        .wdata          (wdata),
        .stall          (stall),
        .rdata          (rdata),
        .rdata_valid    (rdata_valid),
        .exc_misaligned (exc_misaligned),
        .bus_err        (bus_err),
        .dc             (dc_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic count_pulses();
        if (rdata_valid) begin
            rv_cnt++;
            r_cap = rdata;
        end
        if (exc_misaligned) mis_cnt++;
        if (bus_err) err_cnt++;
    endtask

    // Issue one access, ack after wait_n wait cycles (never if wait_n exceeds the timeout),
    // drop the request once the stall clears, then watch one more cycle.
    task automatic run_op(input string name, input logic rd, input logic wr, input logic bw,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int wait_n, input logic [31:0] ack_data);
        bit done = 0;
        int cyc  = 0;
        stall_cnt = 0; req_cnt = 0; rv_cnt = 0; mis_cnt = 0; err_cnt = 0;
        r_cap = '0; a_cap = '0; wd_cap = '0; be_cap = '0; we_cap = 1'b0;
        @(posedge clk); #1;
        memread = rd; memwrite = wr; byteword = bw; addr = a; wdata = wd;
        dc_bus.dc_rdata = ack_data;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            dc_bus.dc_ack = 1'b0;
            if (stall) stall_cnt++;
            if (dc_bus.dc_req) begin
                if (req_cnt == 0) begin
                    a_cap  = dc_bus.dc_addr;
                    be_cap = dc_bus.dc_be;
                    wd_cap = dc_bus.dc_wdata;
                    we_cap = dc_bus.dc_we;
                end
                if (req_cnt == wait_n) dc_bus.dc_ack = 1'b1;
                req_cnt++;
            end
            count_pulses();
            if (!stall) begin
                done = 1;
                memread = 1'b0;
                memwrite = 1'b0;
            end
        end
        if (!done) check({name, "_bound"}, 32'd0, 32'd1);
        @(negedge clk);
        if (stall) stall_cnt++;
        if (dc_bus.dc_req) req_cnt++;
        count_pulses();
        $display("op %s: stall=%0d req=%0d rv=%0d mis=%0d err=%0d rdata=%h be=%b",
                 name, stall_cnt, req_cnt, rv_cnt, mis_cnt, err_cnt, r_cap, be_cap);
    endtask

    initial begin
        reset = 1'b1;
        memread = 1'b0; memwrite = 1'b0; byteword = 1'b0;
        addr = '0; wdata = '0;
        dc_bus.dc_ack = 1'b0; dc_bus.dc_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dc_bus.dc_req), 32'd0);
        check("rst_addr", dc_bus.dc_addr, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_pulses", {29'd0, rdata_valid, exc_misaligned, bus_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Stray ack with no access in flight
        dc_bus.dc_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dc_bus.dc_ack = 1'b0;
        check("idle_ack_req", 32'(dc_bus.dc_req), 32'd0);
        check("idle_ack_rv", 32'(rdata_valid), 32'd0);
        check("idle_ack_stall", 32'(stall), 32'd0);

        run_op("word_load", 1, 0, 1, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        check("wl_addr", a_cap, 32'h100);
        check("wl_be", 32'(be_cap), 32'hF);
        check("wl_we", 32'(we_cap), 32'd0);
        check("wl_stall", stall_cnt, 2);
        check("wl_rv", rv_cnt, 1);
        check("wl_rdata", r_cap, 32'hDEADBEEF);

        run_op("byte_load3", 1, 0, 0, 32'h203, 32'h0, 3, 32'hAABBCCDD);
        check("bl_addr", a_cap, 32'h200);
        check("bl_be", 32'(be_cap), 32'b1000);
        check("bl_stall", stall_cnt, 5);
        check("bl_req", req_cnt, 4);
        check("bl_rv", rv_cnt, 1);
        check("bl_rdata", r_cap, 32'h000000AA);
        check("bl_err", err_cnt, 0);

        run_op("byte_load1", 1, 0, 0, 32'h601, 32'h0, 1, 32'h11223344);
        check("bl1_be", 32'(be_cap), 32'b0010);
        check("bl1_stall", stall_cnt, 3);
        check("bl1_rdata", r_cap, 32'h00000033);

        run_op("byte_store", 0, 1, 0, 32'h301, 32'h12345678, 0, 32'hFFFFFFFF);
        check("bs_we", 32'(we_cap), 32'd1);
        check("bs_addr", a_cap, 32'h300);
        check("bs_be", 32'(be_cap), 32'b0010);
        check("bs_wdata", wd_cap, 32'h78787878);
        check("bs_rv", rv_cnt, 0);
        check("bs_stall", stall_cnt, 2);

        run_op("word_store", 0, 1, 1, 32'h80C, 32'hCAFEF00D, 2, 32'h0);
        check("ws_be", 32'(be_cap), 32'hF);
        check("ws_wdata", wd_cap, 32'hCAFEF00D);
        check("ws_stall", stall_cnt, 4);
        check("ws_rv", rv_cnt, 0);

        run_op("misaligned", 0, 1, 1, 32'h402, 32'h55AA55AA, 0, 32'h0);
        check("mis_pulse", mis_cnt, 1);
        check("mis_req", req_cnt, 0);
        check("mis_stall", stall_cnt, 1);
        check("mis_err", err_cnt, 0);

        run_op("rd_and_wr", 1, 1, 1, 32'h900, 32'h0, 0, 32'h0);
        check("both_err", err_cnt, 1);
        check("both_req", req_cnt, 0);
        check("both_stall", stall_cnt, 1);

        run_op("timeout", 1, 0, 1, 32'h500, 32'h0, 99, 32'h12341234);
        check("to_req", req_cnt, 4);
        check("to_err", err_cnt, 1);
        check("to_rv", rv_cnt, 0);
        check("to_stall", stall_cnt, 5);

        // Reset lands in the second REQ cycle together with the ack
        @(posedge clk); #1;
        memread = 1'b1; memwrite = 1'b0; byteword = 1'b1; addr = 32'h700;
        dc_bus.dc_rdata = 32'h0BADF00D;
        @(negedge clk);
        @(negedge clk);
        check("rm_req_cycle1", 32'(dc_bus.dc_req), 32'd1);
        @(negedge clk);
        dc_bus.dc_ack = 1'b1;
        reset = 1'b1;
        memread = 1'b0;
        @(negedge clk);
        check("rm_req", 32'(dc_bus.dc_req), 32'd0);
        check("rm_stall", 32'(stall), 32'd0);
        check("rm_rv", 32'(rdata_valid), 32'd0);
        dc_bus.dc_ack = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rm_rv_after", 32'(rdata_valid), 32'd0);
        check("rm_rdata", rdata, 32'd0);
        $display("op reset_mid: req=%0b stall=%0b rv=%0b", dc_bus.dc_req, stall, rdata_valid);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage consumer of the decode control signals memread, memwrite and byteword as carried through the EX/MEM pipeline register.
- Turns one load or store per instruction into a request/acknowledge transaction on the data-cache port, with byte lane selection and byte merging.
- Stalls the pipeline until the transaction completes and returns load data to the WB mux.
- Flags misaligned word accesses and data-port timeouts.

Parameters:
- ADDR_W, 32, address width.
- TIMEOUT, 64, maximum cycles to wait for dc_ack before raising bus_err (must be ≥ 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- memread  in  1  MEM-stage load request.
- memwrite  in  1  MEM-stage store request.
- byteword  in  1  0 = byte access, 1 = word access.
- addr  in  ADDR_W  effective address from the ALU.
- wdata  in  32  store data (rt).
- stall  out  1  freezes IF..EX and the EX/MEM register while high (combinational).
- rdata  out  32  formatted load data, registered.
- rdata_valid  out  1  one-cycle pulse: rdata is valid for WB.
- exc_misaligned  out  1  one-cycle pulse on a word access with addr[1:0] ≠ 0.
- bus_err  out  1  one-cycle pulse on timeout, or when memread and memwrite are both high.
- dc_req  out  1  data-port request, registered.
- dc_we  out  1  1 = write, registered.
- dc_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2], 2'b00}, registered.
- dc_be  out  4  byte enables, registered.
- dc_wdata  out  32  write data, registered.
- dc_ack  in  1  data-port completion, valid in the cycle it is sampled.
- dc_rdata  in  32  read word, valid when dc_ack = 1.

Behaviour:
- Reset values: all registered outputs 0; state = IDLE; timeout counter = 0. stall is 0 after reset.
- States:
  - IDLE: a request is present (op = memread | memwrite).
    - If memread and memwrite are both high: pulse bus_err; no request; go to DONE.
    - Else if the access is a misaligned word: pulse exc_misaligned; no request; go to DONE.
    - Else: register dc_addr, dc_be, dc_wdata and dc_we = memwrite, set dc_req = 1, clear the counter, go to REQ.
    - No op: stay in IDLE.
  - REQ: dc_req and all dc_* fields are held stable.
    - Counter increments each cycle.
    - dc_ack = 1:
      - Clear dc_req.
      - On a load, capture the formatted dc_rdata into rdata and set rdata_valid = 1 for the next cycle.
      - Go to DONE.
    - No ack and counter == TIMEOUT-1: clear dc_req, pulse bus_err, go to DONE with rdata_valid = 0.
  - DONE: one cycle; always go to IDLE. The pipeline advances at the end of this cycle, so the same instruction is never issued twice.
- stall = (IDLE & op) | REQ. The stall is low in DONE.
- Latency:
  - Zero-wait ack (ack in the first REQ cycle): stall high for 2 cycles; rdata_valid in the DONE cycle.
  - Each extra wait cycle adds 1 stall cycle.
- Byte lanes are little-endian: addr[1:0] = k selects bits 8k+7:8k.
  - Byte store: dc_be = 1 << addr[1:0]; dc_wdata = {4{wdata[7:0]}}.
  - Word store and word load: dc_be = 4'b1111; dc_wdata = wdata.
  - Byte load: dc_be = 1 << addr[1:0]; rdata = {24'b0, selected byte}, zero-extended.
  - Word load: rdata = dc_rdata.
- Pulses: rdata_valid, exc_misaligned and bus_err are exactly one cycle wide and mutually exclusive. They are asserted in the DONE cycle, registered on the transition into DONE.
- dc_ack outside REQ is ignored.
- Reset mid-transaction: the next edge forces IDLE, dc_req = 0 and all pulses to 0. An ack arriving in that same cycle is discarded.
- byteword = 1 with addr[1:0] = 0 is the only legal word access.

Decomposition:
- Shared define/package:
  - state encodings ST_IDLE, ST_REQ, ST_DONE (2 bits);
  - BE_WORD = 4'b1111;
  - BYTE/WORD encodings matching byteword.
- One sub-module, mem_byte_lane (combinational), produces:
  - dc_be and replicated dc_wdata from (byteword, addr[1:0], wdata);
  - formatted rdata from (byteword, addr[1:0], dc_rdata).
- The FSM, counter and pulse logic stay in mem_access_ctrl.

Test Plan:
- Word load: addr = 0x100, memread = 1, byteword = 1, ack in the first REQ cycle with dc_rdata = 0xDEADBEEF. Expect dc_addr = 0x100, dc_be = 1111, stall high for 2 cycles, then rdata = 0xDEADBEEF with rdata_valid pulsed 1 cycle.
- Byte load: addr = 0x203, dc_rdata = 0xAABBCCDD, ack after 3 wait cycles. Expect dc_be = 1000, rdata = 0x000000AA, stall high for 5 cycles.
- Byte store: addr = 0x301, wdata = 0x12345678. Expect dc_we = 1, dc_be = 0010, dc_wdata = 0x78787878, no rdata_valid.
- Misaligned word store at addr = 0x402. Expect exc_misaligned pulse, dc_req never asserted, stall for 1 cycle.
- Timeout: TIMEOUT = 4, no ack. Expect dc_req high for 4 cycles, then drop; bus_err pulse; return to IDLE.
- Reset asserted in the second REQ cycle, with ack arriving in that same cycle. Expect next cycle IDLE, dc_req = 0, no rdata_valid, stall = 0.
